dpram_fifo_ctrl: RTL and testbench
==================================

Name: dpram_fifo_ctrl

Overview:
Controller that runs a dual_port_sram_32x512 instance as a 512+2 word synchronous FIFO.
- Generates write/read addresses, strobes and fill status.
- Captures the SRAM's 1-cycle registered read data into a 2-entry output buffer, so pop throughput is 1 word/cycle.
- Sits between a producer and a consumer using valid/ready handshakes; the SRAM is instantiated outside the controller, in the parent.

Parameters:
- DATA_W, 32, data width; must match the SRAM.
- ADDR_W, 9, SRAM address width; RAM depth = 2**ADDR_W.
- AF_THRESH, 508, almost_full asserts when level >= AF_THRESH (optional feature only).
- AE_THRESH, 4, almost_empty asserts when level <= AE_THRESH (optional feature only).

Ports:
- clk  in  1  single clock; drives the controller and both SRAM clocks.
- rst_n  in  1  asynchronous active-low reset.
- push_valid  in  1  producer has a word.
- push_ready  out  1  controller can accept a word.
- push_data  in  [0:DATA_W-1]  write word.
- pop_valid  out  1  pop_data holds a valid word.
- pop_ready  in  1  consumer takes the word.
- pop_data  out  [0:DATA_W-1]  head-of-FIFO word.
- mem_wen  out  1  SRAM write enable.
- mem_waddr  out  [0:ADDR_W-1]  SRAM write address.
- mem_wdata  out  [0:DATA_W-1]  SRAM write data (= push_data).
- mem_ren  out  1  SRAM read enable.
- mem_raddr  out  [0:ADDR_W-1]  SRAM read address.
- mem_rdata  in  [0:DATA_W-1]  SRAM d_out; valid the cycle after mem_ren.
- level  out  [0:ADDR_W]  words held: RAM count + in-flight read + buffer count (max 514).

Behaviour:
- Reset (async, rst_n=0): wptr=rptr=0, ram_cnt=0, rd_inflight=0, buffer empty. Outputs: push_ready=1 once released, pop_valid=0, mem_wen=0, mem_ren=0, level=0, pop_data=0. Reset mid-operation discards all contents; no SRAM clearing.
- Push:
  - push_ready = (ram_cnt != 2**ADDR_W), combinational from registers only.
  - Accept = push_valid & push_ready; mem_wen = accept, mem_waddr = wptr.
  - On accept: wptr increments, wrapping 511->0.
- Read issue (combinational):
  - mem_ren = (ram_cnt != 0) & (buf_cnt + rd_inflight - pop_fire < 2), where pop_fire = pop_valid & pop_ready.
  - mem_raddr = rptr. On issue: rptr increments with wrap and rd_inflight <= 1; otherwise rd_inflight <= 0.
- Capture: when rd_inflight=1, mem_rdata is written into the buffer tail that cycle.
- Output buffer:
  - 2-entry register FIFO; pop_valid = (buf_cnt != 0); pop_data = head entry (registered).
  - A simultaneous capture and pop on a full buffer is legal: pop first, then capture.
- ram_cnt: +1 on accepted push, -1 on read issue; a simultaneous push and issue leaves it unchanged.
- Same-cycle push and read to an empty RAM cannot happen, because issue needs ram_cnt != 0 from the previous cycle. This removes read-during-write hazards.
- Latency: push accepted in cycle t -> mem_ren in t+1 -> capture in t+2 -> pop_valid=1 in t+3.
- Throughput: sustained 1 push and 1 pop per cycle with no bubbles once the buffer is primed.
- level never exceeds 514. It is updated from next-state counts and registered.
- push_valid with push_ready=0 has no effect. pop_ready with pop_valid=0 has no effect.

Optional Feature:
- DPRAM_FIFO_CTRL_ALMOST_EN defined: adds registered outputs almost_full (level >= AF_THRESH) and almost_empty (level <= AE_THRESH).
  - Both update in the same cycle as level.
  - Reset values: almost_full=0, almost_empty=1.
- Undefined: the ports, logic and threshold parameters have no effect and are absent from the port list.

Decomposition:
- Package dpram_fifo_pkg: DATA_W=32, ADDR_W=9, RAM_DEPTH=512, OUTBUF_DEPTH=2, LEVEL_W=ADDR_W+1.
- Sub-module dpram_fifo_outbuf: the 2-entry capture/pop register FIFO. It exposes buf_cnt, head data, capture and pop inputs, and has the same clk/rst_n.

Test Plan:
- Reset then single push 0xDEADBEEF at cycle 5 -> mem_wen/mem_waddr=0 at 5, mem_ren at 6, pop_valid=1 with pop_data=0xDEADBEEF at 8; level goes 1 at 6 and stays 1 until popped.
- Push 514 words 0..513 with pop_ready=0 -> push_ready falls after the 514th accept; level=514; the 515th push is ignored; draining then yields 0..513 in order.
- Continuous push/pop for 2000 cycles with pop_ready=1 -> no bubbles after priming, waddr/raddr wrap 511->0 correctly, output equals the input sequence.
- Random pop_ready backpressure (50%) with random push_valid -> scoreboard matches, and no mem_ren is issued while buffer_cnt + inflight = 2.
- Assert rst_n=0 mid-stream with 100 words held -> within the same cycle pop_valid=0, level=0, mem_wen=mem_ren=0; after release a new push of 0x1 emerges first.
- With DPRAM_FIFO_CTRL_ALMOST_EN: fill to 508 -> almost_full=1; drain to 4 -> almost_empty=1; at 5 -> almost_empty=0.

Source files
------------

// File: rtl/dpram_fifo_pkg.sv
// -----------------------------------------------------------------------------
// dpram_fifo_pkg
// Shared constants and types for the dual-port-SRAM backed FIFO controller.
//   DATA_W       : word width (matches dual_port_sram_32x512)
//   ADDR_W       : SRAM address width, RAM_DEPTH = 2**ADDR_W
//   OUTBUF_DEPTH : entries in the registered output buffer
//   LEVEL_W      : width of the fill-level counter (holds up to 514)
//   AF_THRESH / AE_THRESH : default almost_full / almost_empty thresholds,
//                  only used when DPRAM_FIFO_CTRL_ALMOST_EN is defined
// -----------------------------------------------------------------------------
package dpram_fifo_pkg;

   localparam int DATA_W       = 32;
   localparam int ADDR_W       = 9;
   localparam int RAM_DEPTH    = 1 << ADDR_W;
   localparam int OUTBUF_DEPTH = 2;
   localparam int LEVEL_W      = ADDR_W + 1;

   localparam int AF_THRESH    = 508;
   localparam int AE_THRESH    = 4;

   // Occupancy of the 2-entry output buffer.
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_FULL  = 2'd2
   } buf_cnt_e;

endpackage : dpram_fifo_pkg

// File: rtl/dpram_fifo_outbuf.sv
// -----------------------------------------------------------------------------
// dpram_fifo_outbuf
// 2-entry register FIFO that catches the SRAM's registered read data and
// presents the head word from a register.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   capture_i     : write cap_data_i into the tail this cycle
//   cap_data_i    : word arriving from the SRAM
//   pop_i         : consumer takes the head word this cycle
//   buf_cnt_o     : number of words held (0..2)
//   head_o        : head word (registered, 0 after reset)
// A capture and a pop in the same cycle on a full buffer is handled as
// pop first, then capture, so the buffer stays full.
// -----------------------------------------------------------------------------
module dpram_fifo_outbuf
   import dpram_fifo_pkg::*;
#(
   parameter int DATA_W = dpram_fifo_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              capture_i,
   input  logic [DATA_W-1:0] cap_data_i,
   input  logic              pop_i,
   output logic [1:0]        buf_cnt_o,
   output logic [DATA_W-1:0] head_o
);

   buf_cnt_e          cnt_q, cnt_d;
   logic [DATA_W-1:0] head_q, head_d;
   logic [DATA_W-1:0] tail_q, tail_d;

   // NOTE: every signal assigned in always_comb gets a default first so no
   // path leaves it unassigned -- that is what keeps latches from appearing.
   always_comb begin
      cnt_d  = cnt_q;
      head_d = head_q;
      tail_d = tail_q;
      case (cnt_q)
         BUF_EMPTY: begin
            if (capture_i) begin
               head_d = cap_data_i;
               cnt_d  = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (capture_i && pop_i) begin
               head_d = cap_data_i;
            end else if (capture_i) begin
               tail_d = cap_data_i;
               cnt_d  = BUF_FULL;
            end else if (pop_i) begin
               cnt_d  = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (pop_i) begin
               head_d = tail_q;
               if (capture_i) begin
                  tail_d = cap_data_i;
               end else begin
                  cnt_d = BUF_ONE;
               end
            end
         end
         default: cnt_d = BUF_EMPTY;
      endcase
   end

   // NOTE: the two data registers are reset as well: the buffer is tiny and
   // pop_data must read 0 out of reset. The SRAM itself is never cleared.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= BUF_EMPTY;
         head_q <= '0;
         tail_q <= '0;
      end else begin
         cnt_q  <= cnt_d;
         head_q <= head_d;
         tail_q <= tail_d;
      end
   end

   assign buf_cnt_o = cnt_q;
   assign head_o    = head_q;

endmodule : dpram_fifo_outbuf

// File: rtl/dpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// dpram_fifo_ctrl
// Runs an external dual_port_sram_32x512 as a (2**ADDR_W)+2 word synchronous
// FIFO: generates SRAM write/read strobes and addresses, and catches the
// 1-cycle read data in a 2-entry output buffer for 1 word/cycle pops.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   push_valid/ready/data      : producer handshake
//   pop_valid/ready/data       : consumer handshake (pop_data registered)
//   mem_wen/waddr/wdata        : SRAM write port
//   mem_ren/raddr, mem_rdata   : SRAM read port, rdata valid cycle after ren
//   level                      : words held (RAM + in-flight + buffer)
// Optional: defining DPRAM_FIFO_CTRL_ALMOST_EN adds registered almost_full
// (level >= AF_THRESH) and almost_empty (level <= AE_THRESH).
// -----------------------------------------------------------------------------
module dpram_fifo_ctrl
   import dpram_fifo_pkg::*;
#(
   parameter int DATA_W    = dpram_fifo_pkg::DATA_W,
   parameter int ADDR_W    = dpram_fifo_pkg::ADDR_W
`ifdef DPRAM_FIFO_CTRL_ALMOST_EN
   ,
   parameter int AF_THRESH = dpram_fifo_pkg::AF_THRESH,
   parameter int AE_THRESH = dpram_fifo_pkg::AE_THRESH
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push_valid,
   output logic              push_ready,
   input  logic [DATA_W-1:0] push_data,
   output logic              pop_valid,
   input  logic              pop_ready,
   output logic [DATA_W-1:0] pop_data,
   output logic              mem_wen,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ren,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ADDR_W:0]   level
`ifdef DPRAM_FIFO_CTRL_ALMOST_EN
   ,
   output logic              almost_full,
   output logic              almost_empty
`endif
);

   localparam logic [ADDR_W:0] RAM_FULL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [2:0]      OB_DEPTH = 3'(OUTBUF_DEPTH);

   logic [ADDR_W-1:0] wptr_q, rptr_q;
   logic [ADDR_W:0]   ram_cnt_q, ram_cnt_d;
   logic              rd_inflight_q;
   logic [ADDR_W:0]   level_q, level_d;

   logic              accept, issue, pop_fire;
   logic [1:0]        buf_cnt, buf_cnt_d;
   logic [2:0]        held, room;

   // rst_n gates push_ready so no write strobe can leak out while reset is
   // held; once released it is purely a function of the RAM count.
   assign push_ready = rst_n & (ram_cnt_q != RAM_FULL);
   assign accept     = push_valid & push_ready;
   assign pop_valid  = (buf_cnt != 2'd0);
   assign pop_fire   = pop_valid & pop_ready;

   // Issue a read only if the word can land in the buffer: words already in
   // the buffer plus the one in flight, minus this cycle's pop, must be < 2.
   // Written as held < depth + pop to avoid unsigned underflow.
   assign held  = {1'b0, buf_cnt} + {2'b00, rd_inflight_q};
   assign room  = OB_DEPTH + {2'b00, pop_fire};
   assign issue = (ram_cnt_q != '0) && (held < room);

   assign mem_wen   = accept;
   assign mem_waddr = wptr_q;
   assign mem_wdata = push_data;
   assign mem_ren   = issue;
   assign mem_raddr = rptr_q;

   assign ram_cnt_d = ram_cnt_q + (ADDR_W+1)'(accept) - (ADDR_W+1)'(issue);
   // Buffer count after this cycle's capture and pop; modulo-4 intermediate
   // is fine because the true result is always 0..2.
   assign buf_cnt_d = buf_cnt + {1'b0, rd_inflight_q} - {1'b0, pop_fire};
   assign level_d   = ram_cnt_d + (ADDR_W+1)'(issue) + (ADDR_W+1)'(buf_cnt_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q        <= '0;
         rptr_q        <= '0;
         ram_cnt_q     <= '0;
         rd_inflight_q <= 1'b0;
         level_q       <= '0;
      end else begin
         if (accept) wptr_q <= wptr_q + 1'b1;
         if (issue)  rptr_q <= rptr_q + 1'b1;
         ram_cnt_q     <= ram_cnt_d;
         rd_inflight_q <= issue;
         level_q       <= level_d;
      end
   end

   assign level = level_q;

   dpram_fifo_outbuf #(
      .DATA_W (DATA_W)
   ) u_outbuf (
      .clk        (clk),
      .rst_n      (rst_n),
      .capture_i  (rd_inflight_q),
      .cap_data_i (mem_rdata),
      .pop_i      (pop_fire),
      .buf_cnt_o  (buf_cnt),
      .head_o     (pop_data)
   );

`ifdef DPRAM_FIFO_CTRL_ALMOST_EN
   localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(AF_THRESH);
   localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(AE_THRESH);

   logic almost_full_q, almost_empty_q;

   // Derived from level_d so the flags change in the same cycle as level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
      end else begin
         almost_full_q  <= (level_d >= AF_LVL);
         almost_empty_q <= (level_d <= AE_LVL);
      end
   end

   assign almost_full  = almost_full_q;
   assign almost_empty = almost_empty_q;
`endif

endmodule : dpram_fifo_ctrl

// File: tb/tb_dpram_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dpram_fifo_ctrl
// Self-checking bench for dpram_fifo_ctrl with a behavioural 32x512 SRAM.
// Inputs are driven at the falling edge, outputs sampled 1-2 time units later.
// A monitor keeps a data scoreboard plus an independent level / pointer /
// buffer-occupancy model built from observed handshakes.
// -----------------------------------------------------------------------------
module tb_dpram_fifo_ctrl;

   localparam int DW    = 32;
   localparam int AW    = 9;
   localparam int DEPTH = 1 << AW;
   localparam int AF    = 508;
   localparam int AE    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          push_valid = 1'b0;
   logic          push_ready;
   logic [DW-1:0] push_data = '0;
   logic          pop_valid;
   logic          pop_ready = 1'b0;
   logic [DW-1:0] pop_data;
   logic          mem_wen;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ren;
   logic [AW-1:0] mem_raddr;
   logic [DW-1:0] mem_rdata;
   logic [AW:0]   level;
`ifdef DPRAM_FIFO_CTRL_ALMOST_EN
   logic          almost_full;
   logic          almost_empty;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   dpram_fifo_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (push_valid),
      .push_ready (push_ready),
      .push_data  (push_data),
      .pop_valid  (pop_valid),
      .pop_ready  (pop_ready),
      .pop_data   (pop_data),
      .mem_wen    (mem_wen),
      .mem_waddr  (mem_waddr),
      .mem_wdata  (mem_wdata),
      .mem_ren    (mem_ren),
      .mem_raddr  (mem_raddr),
      .mem_rdata  (mem_rdata),
      .level      (level)
`ifdef DPRAM_FIFO_CTRL_ALMOST_EN
      ,
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`endif
   );

   // Behavioural SRAM: registered read, one-cycle latency.
   logic [DW-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (mem_wen) ram[mem_waddr] <= mem_wdata;
      if (mem_ren) mem_rdata <= ram[mem_raddr];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- monitor
   logic [DW-1:0] sb [$];
   int            lvl_m, buf_m, infl_m;
   logic [AW-1:0] wptr_m, rptr_m;

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            sb.delete();
            lvl_m  = 0;
            buf_m  = 0;
            infl_m = 0;
            wptr_m = '0;
            rptr_m = '0;
         end else begin
            int acc, pf;
            acc = (push_valid && push_ready) ? 1 : 0;
            pf  = (pop_valid && pop_ready) ? 1 : 0;
            check("mon_level", level, lvl_m);
            check("mon_pop_valid", pop_valid, (buf_m != 0));
            check("mon_wen", mem_wen, acc);
`ifdef DPRAM_FIFO_CTRL_ALMOST_EN
            check("mon_almost_full", almost_full, (lvl_m >= AF));
            check("mon_almost_empty", almost_empty, (lvl_m <= AE));
`endif
            if (mem_wen) check("mon_waddr", mem_waddr, wptr_m);
            if (mem_ren) begin
               check("mon_raddr", mem_raddr, rptr_m);
               check("mon_ren_room", ((buf_m + infl_m - pf) < 2), 1'b1);
            end
            if (acc == 1) sb.push_back(push_data);
            if (pf == 1) begin
               if (sb.size() == 0) check("mon_sb_underflow", sb.size(), 1);
               else check("mon_pop_data", pop_data, sb.pop_front());
            end
            lvl_m  = lvl_m + acc - pf;
            buf_m  = buf_m + infl_m - pf;
            infl_m = mem_ren ? 1 : 0;
            wptr_m = wptr_m + AW'(acc);
            rptr_m = rptr_m + AW'(infl_m);
         end
      end
   end

   // ------------------------------------------------------------ vector table
   typedef struct {
      logic          pv;
      logic [DW-1:0] pd;
      logic          pr;
      logic          e_wen;
      logic [AW-1:0] e_wa;
      logic          e_ren;
      logic [AW-1:0] e_ra;
      logic          e_pv;
      logic          chk_pd;
      logic [DW-1:0] e_pd;
      logic [AW:0]   e_lvl;
   } vec_t;

   function automatic vec_t mk(input logic pv, input logic [DW-1:0] pd, input logic pr,
                               input logic e_wen, input logic [AW-1:0] e_wa,
                               input logic e_ren, input logic [AW-1:0] e_ra,
                               input logic e_pv, input logic chk_pd,
                               input logic [DW-1:0] e_pd, input logic [AW:0] e_lvl);
      vec_t v;
      v.pv = pv; v.pd = pd; v.pr = pr; v.e_wen = e_wen; v.e_wa = e_wa;
      v.e_ren = e_ren; v.e_ra = e_ra; v.e_pv = e_pv; v.chk_pd = chk_pd;
      v.e_pd = e_pd; v.e_lvl = e_lvl;
      return v;
   endfunction

   task automatic drive(input logic pv, input logic [DW-1:0] pd, input logic pr);
      @(negedge clk);
      push_valid = pv;
      push_data  = pd;
      pop_ready  = pr;
   endtask

   // Pop with push idle until level reads 0, bounded by budget cycles.
   task automatic drain(input string name, input int budget);
      int c = 0;
      while (level != 0 && c < budget) begin
         drive(1'b0, '0, 1'b1);
         #1;
         c++;
      end
      drive(1'b0, '0, 1'b0);
      #3;
      check({name, "_level"}, level, 0);
      check({name, "_sb_empty"}, sb.size(), 0);
   endtask

   // Push count words (data = base + i) with pop_ready low, bounded.
   task automatic fill(input string name, input int count, input logic [DW-1:0] base);
      int acc = 0;
      for (int c = 0; c < count + 50 && acc < count; c++) begin
         drive(1'b1, base + DW'(acc), 1'b0);
         #1;
         if (push_ready) acc++;
      end
      check({name, "_accepts"}, acc, count);
   endtask

   localparam logic [DW-1:0] DB = 32'hDEAD_BEEF;

   initial begin
      vec_t vt [12];
      int   bubbles;
      logic primed;

      vt[0]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 0,  0);
      vt[1]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 0,  0);
      vt[2]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 0,  0);
      vt[3]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 0,  0);
      vt[4]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 0,  0);
      vt[5]  = mk(1, DB, 0, 1, 0, 0, 0, 0, 1, 0,  0);
      vt[6]  = mk(0, 0,  0, 0, 1, 1, 0, 0, 1, 0,  1);
      vt[7]  = mk(0, 0,  0, 0, 1, 0, 1, 0, 1, 0,  1);
      vt[8]  = mk(0, 0,  0, 0, 1, 0, 1, 1, 1, DB, 1);
      vt[9]  = mk(0, 0,  1, 0, 1, 0, 1, 1, 1, DB, 1);
      vt[10] = mk(0, 0,  0, 0, 1, 0, 1, 0, 0, 0,  0);
      vt[11] = mk(0, 0,  0, 0, 1, 0, 1, 0, 0, 0,  0);

      // ---- reset values
      repeat (3) @(negedge clk);
      #1;
      check("rst_pop_valid", pop_valid, 0);
      check("rst_level", level, 0);
      check("rst_pop_data", pop_data, 0);
      check("rst_wen", mem_wen, 0);
      check("rst_ren", mem_ren, 0);
`ifdef DPRAM_FIFO_CTRL_ALMOST_EN
      check("rst_almost_full", almost_full, 0);
      check("rst_almost_empty", almost_empty, 1);
`endif
      @(negedge clk);
      rst_n = 1'b1;

      // ---- single-word latency, table driven
      for (int i = 0; i < 12; i++) begin
         drive(vt[i].pv, vt[i].pd, vt[i].pr);
         #1;
         check($sformatf("v%0d_push_ready", i), push_ready, 1'b1);
         check($sformatf("v%0d_wen", i), mem_wen, vt[i].e_wen);
         check($sformatf("v%0d_waddr", i), mem_waddr, vt[i].e_wa);
         check($sformatf("v%0d_ren", i), mem_ren, vt[i].e_ren);
         check($sformatf("v%0d_raddr", i), mem_raddr, vt[i].e_ra);
         check($sformatf("v%0d_pop_valid", i), pop_valid, vt[i].e_pv);
         if (vt[i].chk_pd) check($sformatf("v%0d_pop_data", i), pop_data, vt[i].e_pd);
         check($sformatf("v%0d_level", i), level, vt[i].e_lvl);
      end

      // ---- fill to 514, overflow attempt, drain in order
      fill("full", DEPTH + 2, 0);
      drive(1'b1, 32'h999, 1'b0);
      #1;
      check("full_push_ready", push_ready, 0);
      check("full_wen", mem_wen, 0);
      check("full_level", level, DEPTH + 2);
      drain("full_drain", 700);

      // ---- continuous push/pop, no bubbles after priming, pointer wrap
      bubbles = 0;
      primed  = 1'b0;
      for (int c = 0; c < 2000; c++) begin
         drive(1'b1, $urandom, 1'b1);
         #1;
         if (pop_valid) primed = 1'b1;
         else if (primed) bubbles++;
      end
      check("stream_primed", primed, 1);
      check("stream_bubbles", bubbles, 0);
      drain("stream_drain", 50);

      // ---- random push / random backpressure
      for (int c = 0; c < 3000; c++) begin
         drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
      end
      drain("rand_drain", 700);

      // ---- reset mid-stream with 100 words held
      fill("mid", 100, 32'h1000);
      drive(1'b0, '0, 1'b0);
      #1;
      check("mid_level", level, 100);
      drive(1'b1, 32'hABCD, 1'b0);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_pop_valid", pop_valid, 0);
      check("mid_rst_level", level, 0);
      check("mid_rst_wen", mem_wen, 0);
      check("mid_rst_ren", mem_ren, 0);
      check("mid_rst_pop_data", pop_data, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      push_valid = 1'b1;
      push_data  = 32'h1;
      pop_ready  = 1'b0;
      begin
         int c = 0;
         drive(1'b0, '0, 1'b0);
         #1;
         while (!pop_valid && c < 10) begin
            drive(1'b0, '0, 1'b0);
            #1;
            c++;
         end
      end
      check("post_rst_pop_valid", pop_valid, 1);
      check("post_rst_first_word", pop_data, 32'h1);
      check("post_rst_level", level, 1);
      drain("post_rst_drain", 20);

`ifdef DPRAM_FIFO_CTRL_ALMOST_EN
      // ---- almost_full / almost_empty thresholds
      fill("af", AF, 32'h2000);
      drive(1'b0, '0, 1'b0);
      #1;
      check("af_level", level, AF);
      check("af_almost_full", almost_full, 1);
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         push_valid = 1'b0;
         pop_ready  = (level > AE + 1);
         #1;
         if (level == AE + 1) break;
      end
      drive(1'b0, '0, 1'b0);
      #1;
      check("ae5_level", level, AE + 1);
      check("ae5_almost_empty", almost_empty, 0);
      check("ae5_almost_full", almost_full, 0);
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b0);
      #1;
      check("ae4_level", level, AE);
      check("ae4_almost_empty", almost_empty, 1);
      drain("ae_drain", 20);
`endif

      repeat (2) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule : tb_dpram_fifo_ctrl
